// File: rtl/mc_control.sv
// mc_control -- multicycle CPU control unit.
//
// Sequences the datapath through fetch, decode, execute and write-back for
// each instruction. It adds a bounded memory-wait watchdog, an optional trap
// on undefined opcodes, and a counter of retired instructions.
//
// Ports
//   clock, reset        system clock; synchronous active-high reset
//   N, Z                ALU negative / zero flags
//   instr[3:0]          opcode field of IR
//   mem_ready           memory completes the current read/write this cycle
//   PCwrite .. Stop     1-bit datapath controls
//   ALU2[2:0]           ALU operand-2 select
//   ALUop[2:0]          ALU operation
//   fault               sticky: illegal opcode or memory timeout
//   retired[CNT_W-1:0]  completed-instruction count (wraps)
module mc_control #(
  parameter int MEM_TIMEOUT  = 16,
  parameter int CNT_W        = 16,
  parameter int TRAP_ILLEGAL = 1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             N,
  input  logic             Z,
  input  logic [3:0]       instr,
  input  logic             mem_ready,
  output logic             PCwrite,
  output logic             MemRead,
  output logic             MemWrite,
  output logic             IRload,
  output logic             R1Sel,
  output logic             MDRload,
  output logic             R1R2Load,
  output logic             ALU1,
  output logic             ALUOutWrite,
  output logic             RFWrite,
  output logic             RegIn,
  output logic             FlagWrite,
  output logic             Stop,
  output logic [2:0]       ALU2,
  output logic [2:0]       ALUop,
  output logic             fault,
  output logic [CNT_W-1:0] retired
);

  // The wait counter only has to reach MEM_TIMEOUT-1.
  localparam int WAIT_W = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
  localparam logic [WAIT_W-1:0] WAIT_LAST =
    (MEM_TIMEOUT > 0) ? WAIT_W'(MEM_TIMEOUT - 1) : '0;

  typedef enum logic [4:0] {
    ST_RST, ST_FETCH, ST_DECODE, ST_ASN, ST_SHIFT, ST_WB,
    ST_ORI1, ST_ORI2, ST_ORI3, ST_LOAD, ST_LOAD_WB, ST_STORE,
    ST_BPZ, ST_BZ, ST_BNZ, ST_STOP, ST_FAULT
  } state_t;

  state_t             r_state;
  state_t             w_next;
  logic [WAIT_W-1:0]  r_wait;
  logic [CNT_W-1:0]   r_retired;
  logic               w_wait_inc;
  logic               w_timeout;
  logic               w_retire;

  // A memory access is waiting whenever a memory state sees mem_ready low.
  // Any other cycle clears the counter, so each access starts from zero.
  always_comb begin
    w_wait_inc = 1'b0;
    if ((r_state == ST_FETCH) || (r_state == ST_LOAD) || (r_state == ST_STORE))
      w_wait_inc = !mem_ready;
  end

  // A ready access is not a timeout, so a late ready still completes the
  // access normally.
  assign w_timeout = (MEM_TIMEOUT > 0) && w_wait_inc && (r_wait == WAIT_LAST);

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state   <= ST_RST;
      r_wait    <= '0;
      r_retired <= '0;
    end else begin
      r_state <= w_next;
      r_wait  <= w_wait_inc ? (r_wait + WAIT_W'(1)) : '0;
      if (w_retire)
        r_retired <= r_retired + CNT_W'(1);
    end
  end

  assign retired = r_retired;

  always_comb begin
    w_next      = r_state;
    w_retire    = 1'b0;
    PCwrite     = 1'b0;
    MemRead     = 1'b0;
    MemWrite    = 1'b0;
    IRload      = 1'b0;
    R1Sel       = 1'b0;
    MDRload     = 1'b0;
    R1R2Load    = 1'b0;
    ALU1        = 1'b0;
    ALUOutWrite = 1'b0;
    RFWrite     = 1'b0;
    RegIn       = 1'b0;
    FlagWrite   = 1'b0;
    Stop        = 1'b0;
    ALU2        = 3'b000;
    ALUop       = 3'b000;
    fault       = 1'b0;

    case (r_state)
      ST_RST: w_next = ST_FETCH;

      ST_FETCH: begin
        MemRead = 1'b1;
        ALU2    = 3'b001;
        if (mem_ready) begin
          PCwrite = 1'b1;
          IRload  = 1'b1;
          w_next  = ST_DECODE;
        end else if (w_timeout) begin
          w_next = ST_FAULT;
        end
      end

      ST_DECODE: begin
        R1R2Load = 1'b1;
        case (instr)
          4'd4, 4'd6, 4'd8: w_next = ST_ASN;
          4'd3, 4'd11:      w_next = ST_SHIFT;
          4'd7, 4'd15:      w_next = ST_ORI1;
          4'd0:             w_next = ST_LOAD;
          4'd2:             w_next = ST_STORE;
          4'd13:            w_next = ST_BPZ;
          4'd5:             w_next = ST_BZ;
          4'd9:             w_next = ST_BNZ;
          4'd1:             w_next = ST_STOP;
          4'd10: begin
            w_next   = ST_FETCH;
            w_retire = 1'b1;
          end
          default: begin
            // Undefined opcodes (12, 14) either trap or behave as nop.
            if (TRAP_ILLEGAL != 0) begin
              w_next = ST_FAULT;
            end else begin
              w_next   = ST_FETCH;
              w_retire = 1'b1;
            end
          end
        endcase
      end

      ST_ASN: begin
        ALU1        = 1'b1;
        ALUOutWrite = 1'b1;
        FlagWrite   = 1'b1;
        case (instr)
          4'd6:    ALUop = 3'b001;
          4'd8:    ALUop = 3'b011;
          default: ALUop = 3'b000;
        endcase
        w_next = ST_WB;
      end

      ST_SHIFT: begin
        ALU1        = 1'b1;
        ALU2        = 3'b100;
        ALUop       = 3'b100;
        ALUOutWrite = 1'b1;
        FlagWrite   = 1'b1;
        w_next      = ST_WB;
      end

      ST_WB: begin
        RFWrite  = 1'b1;
        w_retire = 1'b1;
        w_next   = ST_FETCH;
      end

      ST_ORI1: begin
        R1Sel    = 1'b1;
        R1R2Load = 1'b1;
        w_next   = ST_ORI2;
      end

      ST_ORI2: begin
        ALU1        = 1'b1;
        ALU2        = 3'b011;
        ALUop       = 3'b010;
        ALUOutWrite = 1'b1;
        FlagWrite   = 1'b1;
        w_next      = ST_ORI3;
      end

      ST_ORI3: begin
        R1Sel    = 1'b1;
        RFWrite  = 1'b1;
        w_retire = 1'b1;
        w_next   = ST_FETCH;
      end

      ST_LOAD: begin
        MemRead = 1'b1;
        if (mem_ready) begin
          MDRload = 1'b1;
          w_next  = ST_LOAD_WB;
        end else if (w_timeout) begin
          w_next = ST_FAULT;
        end
      end

      ST_LOAD_WB: begin
        ALUOutWrite = 1'b1;
        RFWrite     = 1'b1;
        RegIn       = 1'b1;
        w_retire    = 1'b1;
        w_next      = ST_FETCH;
      end

      ST_STORE: begin
        MemWrite = 1'b1;
        if (mem_ready) begin
          w_retire = 1'b1;
          w_next   = ST_FETCH;
        end else if (w_timeout) begin
          w_next = ST_FAULT;
        end
      end

      ST_BPZ: begin
        ALU2     = 3'b010;
        PCwrite  = ~N;
        w_retire = 1'b1;
        w_next   = ST_FETCH;
      end

      ST_BZ: begin
        ALU2     = 3'b010;
        PCwrite  = Z;
        w_retire = 1'b1;
        w_next   = ST_FETCH;
      end

      ST_BNZ: begin
        ALU2     = 3'b010;
        PCwrite  = ~Z;
        w_retire = 1'b1;
        w_next   = ST_FETCH;
      end

      ST_STOP: Stop = 1'b1;

      ST_FAULT: begin
        Stop  = 1'b1;
        fault = 1'b1;
      end

      default: w_next = ST_RST;
    endcase
  end

endmodule

// File: tb/tb_mc_control.sv
// tb_mc_control -- directed testbench for mc_control.
// Instance a uses the default parameters. Instance b uses MEM_TIMEOUT=4,
// CNT_W=2 and TRAP_ILLEGAL=0.
module tb_mc_control;

  logic clk;
  logic ra, rb, Na, Za, Nb, Zb, mra, mrb;
  logic [3:0] ia, ib;

  logic a_pc, a_mr, a_mw, a_ir, a_r1s, a_mdr, a_r12, a_a1, a_aow, a_rfw, a_rin, a_fw, a_stp, a_flt;
  logic b_pc, b_mr, b_mw, b_ir, b_r1s, b_mdr, b_r12, b_a1, b_aow, b_rfw, b_rin, b_fw, b_stp, b_flt;
  logic [2:0] a_alu2, a_aluop, b_alu2, b_aluop;
  logic [15:0] ret_a;
  logic [1:0]  ret_b;

  int n_checks = 0;
  int n_errors = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  mc_control dut_a (
    .clock(clk), .reset(ra), .N(Na), .Z(Za), .instr(ia), .mem_ready(mra),
    .PCwrite(a_pc), .MemRead(a_mr), .MemWrite(a_mw), .IRload(a_ir), .R1Sel(a_r1s),
    .MDRload(a_mdr), .R1R2Load(a_r12), .ALU1(a_a1), .ALUOutWrite(a_aow),
    .RFWrite(a_rfw), .RegIn(a_rin), .FlagWrite(a_fw), .Stop(a_stp),
    .ALU2(a_alu2), .ALUop(a_aluop), .fault(a_flt), .retired(ret_a)
  );

  mc_control #(.MEM_TIMEOUT(4), .CNT_W(2), .TRAP_ILLEGAL(0)) dut_b (
    .clock(clk), .reset(rb), .N(Nb), .Z(Zb), .instr(ib), .mem_ready(mrb),
    .PCwrite(b_pc), .MemRead(b_mr), .MemWrite(b_mw), .IRload(b_ir), .R1Sel(b_r1s),
    .MDRload(b_mdr), .R1R2Load(b_r12), .ALU1(b_a1), .ALUOutWrite(b_aow),
    .RFWrite(b_rfw), .RegIn(b_rin), .FlagWrite(b_fw), .Stop(b_stp),
    .ALU2(b_alu2), .ALUop(b_aluop), .fault(b_flt), .retired(ret_b)
  );

  logic [19:0] ctl_a, ctl_b;
  assign ctl_a = {a_pc, a_mr, a_mw, a_ir, a_r1s, a_mdr, a_r12, a_a1, a_aow, a_rfw,
                  a_rin, a_fw, a_stp, a_alu2, a_aluop, a_flt};
  assign ctl_b = {b_pc, b_mr, b_mw, b_ir, b_r1s, b_mdr, b_r12, b_a1, b_aow, b_rfw,
                  b_rin, b_fw, b_stp, b_alu2, b_aluop, b_flt};

  localparam logic [12:0] F_PC  = 13'h1000, F_MR  = 13'h0800, F_MW  = 13'h0400,
                          F_IR  = 13'h0200, F_R1S = 13'h0100, F_MDR = 13'h0080,
                          F_R12 = 13'h0040, F_A1  = 13'h0020, F_AOW = 13'h0010,
                          F_RFW = 13'h0008, F_RIN = 13'h0004, F_FW  = 13'h0002,
                          F_STP = 13'h0001;

  function automatic logic [19:0] mk(input logic [12:0] f, input logic [2:0] alu2,
                                     input logic [2:0] aluop, input logic flt);
    return {f, alu2, aluop, flt};
  endfunction

  localparam logic [19:0] E_FETCH_WAIT = mk(F_MR, 3'b001, 3'b000, 1'b0);
  localparam logic [19:0] E_FETCH_RDY  = mk(F_PC | F_MR | F_IR, 3'b001, 3'b000, 1'b0);
  localparam logic [19:0] E_DECODE     = mk(F_R12, 3'b000, 3'b000, 1'b0);
  localparam logic [19:0] E_ASN_ADD    = mk(F_A1 | F_AOW | F_FW, 3'b000, 3'b000, 1'b0);
  localparam logic [19:0] E_ASN_SUB    = mk(F_A1 | F_AOW | F_FW, 3'b000, 3'b001, 1'b0);
  localparam logic [19:0] E_WB         = mk(F_RFW, 3'b000, 3'b000, 1'b0);
  localparam logic [19:0] E_BR_N       = mk(13'h0, 3'b010, 3'b000, 1'b0);
  localparam logic [19:0] E_BR_T       = mk(F_PC, 3'b010, 3'b000, 1'b0);
  localparam logic [19:0] E_STORE      = mk(F_MW, 3'b000, 3'b000, 1'b0);
  localparam logic [19:0] E_LOAD_WAIT  = mk(F_MR, 3'b000, 3'b000, 1'b0);
  localparam logic [19:0] E_LOAD_RDY   = mk(F_MR | F_MDR, 3'b000, 3'b000, 1'b0);
  localparam logic [19:0] E_LOAD_WB    = mk(F_AOW | F_RFW | F_RIN, 3'b000, 3'b000, 1'b0);
  localparam logic [19:0] E_STOP       = mk(F_STP, 3'b000, 3'b000, 1'b0);
  localparam logic [19:0] E_FAULT      = mk(F_STP, 3'b000, 3'b000, 1'b1);

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    ra = 1; rb = 1; ia = 0; ib = 0; mra = 0; mrb = 0;
    Na = 0; Za = 0; Nb = 0; Zb = 0;
    tick(); tick();
    #1 chk("a_rst_ctl", ctl_a, 20'h0);
    chk("a_rst_ret", ret_a, 0);
    ra = 0; tick();

    // add with memory always ready
    ia = 4; mra = 1;
    #1 chk("a_add_fetch", ctl_a, E_FETCH_RDY); tick();
    #1 chk("a_add_decode", ctl_a, E_DECODE); tick();
    #1 chk("a_add_asn", ctl_a, E_ASN_ADD); tick();
    #1 chk("a_add_wb", ctl_a, E_WB);
    chk("a_ret_before_wb", ret_a, 0); tick();
    #1 chk("a_ret_add", ret_a, 1);

    // sub with a fetch stalled for three cycles
    ia = 6; mra = 0;
    for (int i = 0; i < 3; i++) begin
      #1 chk("a_fetch_wait", ctl_a, E_FETCH_WAIT); tick();
    end
    mra = 1;
    #1 chk("a_fetch_late_rdy", ctl_a, E_FETCH_RDY); tick();
    tick();
    #1 chk("a_sub_asn", ctl_a, E_ASN_SUB); tick();
    tick();
    #1 chk("a_ret_sub", ret_a, 2);

    // bz not taken
    ia = 5; Za = 0;
    tick(); tick();
    #1 chk("a_bz_z0", ctl_a, E_BR_N); tick();
    #1 chk("a_ret_bz", ret_a, 3);

    // bpz taken
    ia = 13; Na = 0;
    tick(); tick();
    #1 chk("a_bpz_n0", ctl_a, E_BR_T); tick();
    #1 chk("a_ret_bpz", ret_a, 4);

    // store interrupted by reset while waiting
    ia = 2;
    tick(); tick();
    mra = 0;
    #1 chk("a_store_wait1", ctl_a, E_STORE); tick();
    #1 chk("a_store_wait2", ctl_a, E_STORE);
    ra = 1; tick();
    #1 chk("a_store_rst_ctl", ctl_a, 20'h0);
    chk("a_store_rst_ret", ret_a, 0);
    ra = 0; tick();

    // illegal opcode traps
    ia = 12; mra = 1;
    tick(); tick();
    #1 chk("a_illegal_fault", ctl_a, E_FAULT); tick();
    #1 chk("a_fault_sticky", ctl_a, E_FAULT);
    chk("a_fault_ret", ret_a, 0);

    // reset out of FAULT, then stop
    ra = 1; tick();
    #1 chk("a_fault_rst", ctl_a, 20'h0);
    ra = 0; tick();
    ia = 1;
    tick(); tick();
    #1 chk("a_stop", ctl_a, E_STOP); tick(); tick();
    #1 chk("a_stop_hold", ctl_a, E_STOP);
    chk("a_stop_ret", ret_a, 0);

    // instance b: illegal opcode behaves as nop
    rb = 0; tick();
    ib = 12; mrb = 1;
    tick();
    #1 chk("b_ill_decode", ctl_b, E_DECODE); tick();
    #1 chk("b_ill_to_fetch", ctl_b, E_FETCH_RDY);
    chk("b_ret_ill", ret_b, 1);

    // three nops: 2-bit counter wraps after the fourth retire
    ib = 10;
    for (int k = 0; k < 3; k++) begin
      tick(); tick();
      #1 chk("b_ret_wrap", ret_b, (k + 2) % 4);
    end

    // load whose ready arrives on the last allowed wait cycle
    ib = 0; mrb = 1;
    tick(); tick();
    mrb = 0;
    for (int i = 0; i < 3; i++) begin
      #1 chk("b_load_wait", ctl_b, E_LOAD_WAIT); tick();
    end
    mrb = 1;
    #1 chk("b_load_rdy_last", ctl_b, E_LOAD_RDY); tick();
    #1 chk("b_load_wb", ctl_b, E_LOAD_WB); tick();
    #1 chk("b_ret_load", ret_b, 1);

    // load that never completes times out after four cycles
    tick(); tick();
    mrb = 0;
    for (int i = 0; i < 4; i++) begin
      #1 chk("b_to_wait", ctl_b, E_LOAD_WAIT); tick();
    end
    #1 chk("b_timeout_fault", ctl_b, E_FAULT);
    chk("b_timeout_ret", ret_b, 1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/mc_control.md
MC_CONTROL -- requirements
Module: mc_control

Interface
REQ-001 Parameter MEM_TIMEOUT, default 16: max consecutive not-ready cycles per memory access; 0 disables the timeout.
REQ-002 Parameter CNT_W, default 16: width of the retired-instruction counter.
REQ-003 Parameter TRAP_ILLEGAL, default 1: 1 = undefined opcodes go to FAULT; 0 = treated as NOP.
REQ-004 One clock; reset is synchronous and active-high.
REQ-005 clock  in  1  system clock; all state changes on its rising edge.
REQ-006 reset  in  1  synchronous, active-high reset.
REQ-007 N, Z  in  1 each  ALU negative/zero flags.
REQ-008 instr  in  4  opcode field of IR.
REQ-009 mem_ready  in  1  memory completes the current read/write in this cycle.
REQ-010 PCwrite, MemRead, MemWrite, IRload, R1Sel, MDRload, R1R2Load, ALU1, ALUOutWrite, RFWrite, RegIn, FlagWrite, Stop  out  1 each  datapath controls.
REQ-011 ALU2, ALUop  out  3 each  ALU operand-2 select and operation.
REQ-012 fault  out  1  sticky: illegal opcode or memory timeout.
REQ-013 retired  out  CNT_W  count of completed instructions.

Function
REQ-014 Opcodes: load 0, stop 1, store 2, add 4, bz 5, sub 6, nand 8, bnz 9, nop 10, bpz 13; instr[2:0]=3 shift; instr[2:0]=7 ori; 12 and 14 illegal.
REQ-015 States: RST, FETCH, DECODE, ASN, SHIFT, WB, ORI1, ORI2, ORI3, LOAD, LOAD_WB, STORE, BPZ, BZ, BNZ, STOP, FAULT.
REQ-016 Every output not listed for a state is 0; outputs are combinational from state, instr, N, Z and mem_ready.
REQ-017 RST: all outputs 0; next FETCH.
REQ-018 FETCH: MemRead=1, ALU2=001, ALUop=000; if mem_ready, also PCwrite=1 and IRload=1, next DECODE; otherwise stay.
REQ-019 DECODE: R1R2Load=1; next per opcode: add/sub/nand->ASN, shift->SHIFT, ori->ORI1, load->LOAD, store->STORE, bpz/bz/bnz->BPZ/BZ/BNZ, nop->FETCH, stop->STOP, illegal->FAULT (TRAP_ILLEGAL=1) or FETCH (TRAP_ILLEGAL=0).
REQ-020 ASN: ALU1=1, ALU2=000, ALUop = 000 add / 001 sub / 011 nand, ALUOutWrite=1, FlagWrite=1; next WB.
REQ-021 SHIFT: ALU1=1, ALU2=100, ALUop=100, ALUOutWrite=1, FlagWrite=1; next WB.
REQ-022 WB: RFWrite=1; next FETCH.
REQ-023 ORI1: R1Sel=1, R1R2Load=1; next ORI2. ORI2: ALU1=1, ALU2=011, ALUop=010, ALUOutWrite=1, FlagWrite=1; next ORI3. ORI3: R1Sel=1, RFWrite=1; next FETCH.
REQ-024 LOAD: MemRead=1; if mem_ready, also MDRload=1, next LOAD_WB; otherwise stay. LOAD_WB: ALUOutWrite=1, RFWrite=1, RegIn=1; next FETCH.
REQ-025 STORE: MemWrite=1 held until the mem_ready cycle; then next FETCH.
REQ-026 BPZ/BZ/BNZ: ALU2=010; PCwrite = ~N / Z / ~Z respectively; next FETCH.
REQ-027 STOP: Stop=1; remains until reset.
REQ-028 FAULT: Stop=1, fault=1; remains until reset.
REQ-029 Wait counter: cleared on entry to FETCH, LOAD or STORE; increments each cycle in those states with mem_ready=0.
REQ-030 Timeout: if MEM_TIMEOUT>0 and mem_ready=0 for MEM_TIMEOUT consecutive cycles of one access, next state FAULT and no PCwrite/IRload/MDRload pulses.
REQ-031 mem_ready in the cycle the counter reaches MEM_TIMEOUT-1 completes the access normally; ready takes priority over timeout.
REQ-032 retired increments by 1, modulo 2^CNT_W, in the final cycle of each instruction: WB, ORI3, LOAD_WB, STORE completion, BPZ/BZ/BNZ, DECODE with nop, or DECODE with illegal when TRAP_ILLEGAL=0; STOP and FAULT do not count.
REQ-033 mem_ready is ignored outside FETCH, LOAD and STORE.

Reset
REQ-034 reset=1 at a clock edge forces RST, clears the wait counter, retired and fault, from any state including mid-access, STOP and FAULT.
REQ-035 Outputs follow RST (all 0) in the cycle after the reset edge; the first FETCH follows one cycle after reset deasserts.

Verification
REQ-036 add (4) with mem_ready=1 -> FETCH, DECODE, ASN(ALUop=000), WB, FETCH; retired +1.
REQ-037 Fetch with mem_ready low 3 cycles -> MemRead=1 for 4 cycles; PCwrite/IRload only in the 4th cycle.
REQ-038 MEM_TIMEOUT=4, load, mem_ready never high -> 4 cycles in LOAD, then FAULT; fault=1, Stop=1, MDRload never 1.
REQ-039 instr=12, TRAP_ILLEGAL=1 -> FAULT after DECODE; with TRAP_ILLEGAL=0 -> FETCH, retired +1.
REQ-040 bz, Z=0 -> PCwrite=0 in BZ; bpz, N=0 -> PCwrite=1; CNT_W=2 after 4 retires -> retired=0.
REQ-041 reset asserted in STORE wait -> MemWrite 0 the next cycle; retired=0 and fault=0.
